// File: rtl/huff_pkg.sv
// Shared constants, table entry type and controller states for the Huffman
// frequency-counting front end.
package huff_pkg;

  localparam int MAX_CHAR_COUNT = 3;
  localparam int FREQ_W         = 3;
  localparam int CHAR_W         = 8;
  localparam int WORD_W         = 1 + FREQ_W + CHAR_W;
  localparam int IDX_W          = (MAX_CHAR_COUNT > 1) ? $clog2(MAX_CHAR_COUNT) : 1;

  localparam logic [FREQ_W-1:0] FREQ_MAX = {FREQ_W{1'b1}};

  typedef struct packed {
    logic              vld;
    logic [CHAR_W-1:0] ch;
    logic [FREQ_W-1:0] freq;
  } freq_entry_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EMIT    = 2'd1,
    HOLD    = 2'd2
  } fc_state_t;

  // Unused slots are all-zero, so they naturally emit as {1,0,0}.
  function automatic logic [WORD_W-1:0] entry_word(input freq_entry_t e);
    return {1'b1, e.freq, e.ch};
  endfunction

endpackage

// File: rtl/huff_sym_match.sv
// Combinational lookup of one character against the frequency table:
// reports a matching valid entry and the lowest free slot.
module huff_sym_match
  import huff_pkg::*;
(
  input  freq_entry_t        entries_i [MAX_CHAR_COUNT],
  input  logic [CHAR_W-1:0]  sym_i,
  output logic               hit_o,
  output logic [IDX_W-1:0]   hit_idx_o,
  output logic               free_avail_o,
  output logic [IDX_W-1:0]   free_idx_o
);

  always_comb begin
    hit_o        = 1'b0;
    hit_idx_o    = '0;
    free_avail_o = 1'b0;
    free_idx_o   = '0;
    // First match / first free wins, giving priority to the lowest index.
    for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
      if (entries_i[i].vld && (entries_i[i].ch == sym_i) && !hit_o) begin
        hit_o     = 1'b1;
        hit_idx_o = IDX_W'(i);
      end
      if (!entries_i[i].vld && !free_avail_o) begin
        free_avail_o = 1'b1;
        free_idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/huff_freq_counter.sv
// Counts distinct characters of one string, streams the table to the encoder
// one word per cycle, then holds until the encoder finishes the vector.
module huff_freq_counter
  import huff_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              sym_valid,
  input  logic [CHAR_W-1:0] sym_data,
  input  logic              sym_last,
  output logic              sym_ready,
  input  logic              vector_done,
  output logic [WORD_W-1:0] out_word,
  output logic              overflow_err,
  output logic              sat_flag,
  output fc_state_t         dbg_state
);

  // Handshake: a character transfers on any rising edge where sym_valid and
  // sym_ready are both high; sym_ready depends only on state, never on inputs.

  fc_state_t         state_q, state_d;
  freq_entry_t       table_q [MAX_CHAR_COUNT];
  freq_entry_t       table_d [MAX_CHAR_COUNT];
  logic [IDX_W-1:0]  emit_idx_q, emit_idx_d;
  logic [WORD_W-1:0] out_word_q, out_word_d;
  logic              ovf_q, ovf_d;
  logic              sat_q, sat_d;

  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic              free_avail;
  logic [IDX_W-1:0]  free_idx;
  logic [IDX_W-1:0]  next_idx;

  huff_sym_match u_match (
    .entries_i    (table_q),
    .sym_i        (sym_data),
    .hit_o        (hit),
    .hit_idx_o    (hit_idx),
    .free_avail_o (free_avail),
    .free_idx_o   (free_idx)
  );

  assign next_idx = emit_idx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    table_d    = table_q;
    emit_idx_d = emit_idx_q;
    out_word_d = '0;
    ovf_d      = ovf_q;
    sat_d      = sat_q;
    case (state_q)
      COLLECT: begin
        if (sym_valid) begin
          if (hit) begin
            if (table_q[hit_idx].freq == FREQ_MAX) sat_d = 1'b1;
            else table_d[hit_idx].freq = table_q[hit_idx].freq + 1'b1;
          end else if (free_avail) begin
            table_d[free_idx].vld  = 1'b1;
            table_d[free_idx].ch   = sym_data;
            table_d[free_idx].freq = FREQ_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
          // Entry 0 must already reflect the last character when it appears.
          if (sym_last) begin
            state_d    = EMIT;
            emit_idx_d = '0;
            out_word_d = entry_word(table_d[0]);
          end
        end
      end
      EMIT: begin
        if (emit_idx_q == IDX_W'(MAX_CHAR_COUNT - 1)) begin
          state_d = HOLD;
        end else begin
          emit_idx_d = next_idx;
          out_word_d = entry_word(table_q[next_idx]);
        end
      end
      HOLD: begin
        if (vector_done) begin
          state_d = COLLECT;
          ovf_d   = 1'b0;
          sat_d   = 1'b0;
          for (int i = 0; i < MAX_CHAR_COUNT; i++) table_d[i] = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= COLLECT;
      emit_idx_q <= '0;
      out_word_q <= '0;
      ovf_q      <= 1'b0;
      sat_q      <= 1'b0;
      for (int i = 0; i < MAX_CHAR_COUNT; i++) table_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      emit_idx_q <= emit_idx_d;
      out_word_q <= out_word_d;
      ovf_q      <= ovf_d;
      sat_q      <= sat_d;
      for (int i = 0; i < MAX_CHAR_COUNT; i++) table_q[i] <= table_d[i];
    end
  end

  assign sym_ready    = (state_q == COLLECT);
  assign out_word     = out_word_q;
  assign overflow_err = ovf_q;
  assign sat_flag     = sat_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_huff_freq_counter.sv
// Directed and randomized checks of huff_freq_counter against a string-level
// reference model of the character counting rules.
module tb_huff_freq_counter;
  import huff_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sym_valid = 1'b0;
  logic [7:0]  sym_data = '0;
  logic        sym_last = 1'b0;
  logic        vector_done = 1'b0;
  logic        sym_ready;
  logic [11:0] out_word;
  logic        overflow_err;
  logic        sat_flag;
  fc_state_t   dbg_state;

  int checks = 0;
  int failures = 0;

  huff_freq_counter dut (
    .clk          (clk),
    .reset        (reset),
    .sym_valid    (sym_valid),
    .sym_data     (sym_data),
    .sym_last     (sym_last),
    .sym_ready    (sym_ready),
    .vector_done  (vector_done),
    .out_word     (out_word),
    .overflow_err (overflow_err),
    .sat_flag     (sat_flag),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Counting rules applied to the whole string: first-seen slot order,
  // saturation at 7, characters beyond three distinct ones are dropped.
  task automatic model(input string s, output logic [11:0] w0, output logic [11:0] w1,
                       output logic [11:0] w2, output logic ovf, output logic sat);
    logic [7:0]  ch[$];
    int          fr[$];
    logic [11:0] w[3];
    ovf = 1'b0;
    sat = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      int found = -1;
      for (int k = 0; k < ch.size(); k++) if (ch[k] == 8'(s[i])) found = k;
      if (found >= 0) begin
        if (fr[found] == 7) sat = 1'b1;
        else fr[found] = fr[found] + 1;
      end else if (ch.size() < 3) begin
        ch.push_back(8'(s[i]));
        fr.push_back(1);
      end else begin
        ovf = 1'b1;
      end
    end
    for (int k = 0; k < 3; k++)
      w[k] = (k < ch.size()) ? {1'b1, 3'(fr[k]), ch[k]} : 12'h800;
    w0 = w[0];
    w1 = w[1];
    w2 = w[2];
  endtask

  // Drives one character per negedge; returns at the negedge after the last
  // character's accepting edge, where the first table word is due.
  task automatic send_str(input string s, input bit last);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      chk("sym_ready_collect", 32'(sym_ready), 32'd1);
      sym_valid = 1'b1;
      sym_data  = 8'(s[i]);
      sym_last  = last && (i == s.len() - 1);
    end
    @(negedge clk);
    sym_valid = 1'b0;
    sym_last  = 1'b0;
  endtask

  task automatic check_emit(input string tag, input logic [11:0] w0, input logic [11:0] w1,
                            input logic [11:0] w2);
    chk({tag, "_w0"}, 32'(out_word), 32'(w0));
    @(negedge clk);
    chk({tag, "_w1"}, 32'(out_word), 32'(w1));
    @(negedge clk);
    chk({tag, "_w2"}, 32'(out_word), 32'(w2));
    @(negedge clk);
    chk({tag, "_hold_valid"}, 32'(out_word[11]), 32'd0);
    chk({tag, "_hold_ready"}, 32'(sym_ready), 32'd0);
    chk({tag, "_hold_state"}, 32'(dbg_state), 32'(HOLD));
  endtask

  task automatic check_flags(input string tag, input logic ovf, input logic sat);
    chk({tag, "_overflow_err"}, 32'(overflow_err), 32'(ovf));
    chk({tag, "_sat_flag"}, 32'(sat_flag), 32'(sat));
  endtask

  task automatic pulse_done(input string tag);
    vector_done = 1'b1;
    @(negedge clk);
    vector_done = 1'b0;
    chk({tag, "_ready_after_done"}, 32'(sym_ready), 32'd1);
    check_flags({tag, "_cleared"}, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] e0, e1, e2;
    logic        eo, es;

    repeat (2) @(negedge clk);
    chk("rst_out_word", 32'(out_word), 32'd0);
    chk("rst_sym_ready", 32'(sym_ready), 32'd1);
    check_flags("rst", 1'b0, 1'b0);
    chk("rst_state", 32'(dbg_state), 32'(COLLECT));
    reset = 1'b0;

    send_str("aab", 1'b1);
    check_emit("aab", 12'hA61, 12'h962, 12'h800);
    check_flags("aab", 1'b0, 1'b0);
    pulse_done("aab");

    send_str("xxxxxxxxx", 1'b1);
    check_emit("x9", 12'hF78, 12'h800, 12'h800);
    check_flags("x9", 1'b0, 1'b1);
    pulse_done("x9");

    send_str("abcd", 1'b1);
    check_emit("abcd", 12'h961, 12'h962, 12'h963);
    check_flags("abcd", 1'b1, 1'b0);

    // Characters offered while holding must be ignored.
    for (int i = 0; i < 10; i++) begin
      sym_valid = 1'b1;
      sym_data  = 8'h7A;
      sym_last  = 1'b1;
      @(negedge clk);
      chk("hold_z_ready", 32'(sym_ready), 32'd0);
      chk("hold_z_valid_bit", 32'(out_word[11]), 32'd0);
    end
    sym_valid = 1'b0;
    sym_last  = 1'b0;
    pulse_done("abcd");

    send_str("cc", 1'b1);
    check_emit("cc", 12'hA63, 12'h800, 12'h800);
    pulse_done("cc");

    send_str("ab", 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst_out_word", 32'(out_word), 32'd0);
    chk("midrst_sym_ready", 32'(sym_ready), 32'd1);
    check_flags("midrst", 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    send_str("b", 1'b1);
    check_emit("after_rst_b", 12'h962, 12'h800, 12'h800);
    pulse_done("after_rst_b");

    // vector_done during EMIT must not cut the emission short.
    send_str("aab", 1'b1);
    chk("vd_emit_w0", 32'(out_word), 32'hA61);
    vector_done = 1'b1;
    @(negedge clk);
    vector_done = 1'b0;
    chk("vd_emit_w1", 32'(out_word), 32'h962);
    @(negedge clk);
    chk("vd_emit_w2", 32'(out_word), 32'h800);
    repeat (4) @(negedge clk);
    chk("vd_emit_still_hold", 32'(dbg_state), 32'(HOLD));
    chk("vd_emit_ready", 32'(sym_ready), 32'd0);
    pulse_done("vd_emit");

    for (int v = 0; v < 25; v++) begin
      string s, t;
      int    len;
      s   = "";
      t   = " ";
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        t[0] = 8'(8'h61 + $urandom_range(0, 4));
        s = {s, t};
      end
      model(s, e0, e1, e2, eo, es);
      send_str(s, 1'b1);
      check_emit("rand", e0, e1, e2);
      check_flags("rand", eo, es);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pulse_done("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
